montador_palavra_16b: RTL and testbench

Byte-to-word assembler that sits directly upstream of the 16-bit load register. It accepts 8-bit data from a byte source over a valid/ready handshake and combines two consecutive bytes into one 16-bit word. It presents the word on `valor` with a single-cycle `load` pulse, so the register captures it on the next clock edge. It also counts delivered words and flags an abandoned half-word after a configurable timeout.

---
 rtl/montador_palavra_16b_pkg.sv | 27 ++
 rtl/montador_palavra_16b_contador_timeout.sv | 31 +++
 rtl/montador_palavra_16b.sv | 123 ++++++++++++
 tb/tb_montador_palavra_16b.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/montador_palavra_16b_pkg.sv
// Shared definitions for the byte-to-word assembler: FSM codes, widths and defaults.
// Optional idle timeout is controlled by the MONTADOR_TIMEOUT_EN macro in the top file.
package montador_palavra_16b_pkg;

   localparam int LARGURA_PALAVRA = 16;
   localparam int LARGURA_BYTE    = 8;
   localparam int TIMEOUT_PADRAO  = 255;

   typedef enum logic [1:0] {
      ESPERA_PRIMEIRO = 2'd0,
      ESPERA_SEGUNDO  = 2'd1,
      ENTREGA         = 2'd2
   } estado_t;

   // Places the two bytes in their halves according to the byte-order parameter.
   function automatic logic [LARGURA_PALAVRA-1:0] monta_palavra(
      input logic                    alto_primeiro,
      input logic [LARGURA_BYTE-1:0] primeiro,
      input logic [LARGURA_BYTE-1:0] segundo
   );
      if (alto_primeiro)
         return {primeiro, segundo};
      else
         return {segundo, primeiro};
   endfunction

endpackage

// File: rtl/montador_palavra_16b_contador_timeout.sv
// Idle counter for the half-word wait: counts enabled cycles and flags the last allowed one.
// Used only when the top is built with MONTADOR_TIMEOUT_EN.
module contador_timeout
   import montador_palavra_16b_pkg::*;
#(
   parameter int LIMITE = TIMEOUT_PADRAO
) (
   input  logic clock,
   input  logic reset,
   input  logic limpa,
   input  logic habilita,
   output logic expirou
);

   localparam logic [7:0] ULTIMO = 8'(LIMITE - 1);

   logic [7:0] contagem;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         contagem <= 8'd0;
      else if (limpa)
         contagem <= 8'd0;
      else if (habilita && (contagem != ULTIMO))
         contagem <= contagem + 8'd1;
   end

   // High during the cycle whose closing edge would be the Nth idle edge.
   assign expirou = habilita && (contagem == ULTIMO);

endmodule

// File: rtl/montador_palavra_16b.sv
// Byte-to-word assembler: two handshaked bytes become one registered 16-bit word plus a load strobe.
// Define MONTADOR_TIMEOUT_EN to compile in the half-word idle timeout and erro_timeout flag.
module montador_palavra_16b
   import montador_palavra_16b_pkg::*;
#(
   parameter int BYTE_ALTO_PRIMEIRO = 0,
   parameter int TIMEOUT_CICLOS     = TIMEOUT_PADRAO
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  dado,
   input  logic        dado_valido,
   output logic        pronto,
   output logic [15:0] valor,
   output logic        load,
   output logic [7:0]  palavras,
   output logic        erro_timeout,
   input  logic        limpa_erro,
   output logic [1:0]  estado
);

   // Handshake: a byte transfers on a rising edge only when dado_valido and pronto are
   // both high in the preceding cycle; a byte offered while pronto is low is dropped.

   estado_t    estado_atual;
   estado_t    proximo_estado;
   logic       aceita;
   logic       segundo_aceito;
   logic       expira;
   logic [7:0] meio;

   assign aceita         = dado_valido && pronto;
   assign segundo_aceito = aceita && (estado_atual == ESPERA_SEGUNDO);
   assign estado         = estado_atual;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         estado_atual <= ESPERA_PRIMEIRO;
      else
         estado_atual <= proximo_estado;
   end

   always_comb begin
      proximo_estado = estado_atual;
      pronto         = 1'b1;
      case (estado_atual)
         ESPERA_PRIMEIRO: begin
            if (aceita)
               proximo_estado = ESPERA_SEGUNDO;
         end
         ESPERA_SEGUNDO: begin
            if (aceita)
               proximo_estado = ENTREGA;
            else if (expira)
               proximo_estado = ESPERA_PRIMEIRO;
         end
         ENTREGA: begin
            pronto         = 1'b0;
            proximo_estado = ESPERA_PRIMEIRO;
         end
         default: begin
            proximo_estado = ESPERA_PRIMEIRO;
         end
      endcase
   end

   // The first byte waits in meio so valor keeps showing the last delivered word.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meio     <= 8'h00;
         valor    <= 16'h0000;
         load     <= 1'b0;
         palavras <= 8'h00;
      end else begin
         load <= segundo_aceito;
         if (aceita && (estado_atual == ESPERA_PRIMEIRO))
            meio <= dado;
         if (segundo_aceito)
            valor <= monta_palavra(BYTE_ALTO_PRIMEIRO != 0, meio, dado);
         if (estado_atual == ENTREGA)
            palavras <= palavras + 8'd1;
      end
   end

`ifdef MONTADOR_TIMEOUT_EN
   logic expirou;
   logic habilita_contador;
   logic limpa_contador;

   assign habilita_contador = (estado_atual == ESPERA_SEGUNDO);
   assign limpa_contador    = !habilita_contador || aceita || expirou;

   contador_timeout #(
      .LIMITE (TIMEOUT_CICLOS)
   ) u_contador_timeout (
      .clock    (clock),
      .reset    (reset),
      .limpa    (limpa_contador),
      .habilita (habilita_contador),
      .expirou  (expirou)
   );

   // A byte arriving on the expiry cycle completes the word instead of timing out.
   assign expira = expirou && !aceita;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         erro_timeout <= 1'b0;
      else if (expira)
         erro_timeout <= 1'b1;
      else if (limpa_erro)
         erro_timeout <= 1'b0;
   end
`else
   localparam int unused_timeout_ciclos = TIMEOUT_CICLOS;
   logic unused_limpa_erro;

   assign unused_limpa_erro = limpa_erro;
   assign expira            = 1'b0;
   assign erro_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_montador_palavra_16b.sv
// Directed bench for montador_palavra_16b: low-byte-first instance with a 4-cycle timeout
// plus a high-byte-first instance sharing the same stimulus.
module tb_montador_palavra_16b;
   import montador_palavra_16b_pkg::*;

   logic        clock;
   logic        reset;
   logic [7:0]  dado;
   logic        dado_valido;
   logic        limpa_erro;

   logic        pronto;
   logic [15:0] valor;
   logic        load;
   logic [7:0]  palavras;
   logic        erro_timeout;
   logic [1:0]  estado;

   logic        pronto_b;
   logic [15:0] valor_b;
   logic        load_b;
   logic [7:0]  palavras_b;
   logic        erro_timeout_b;
   logic [1:0]  estado_b;

   logic [15:0] registro;

   int n_assert;
   int n_fail;
   int exp_palavras;

   montador_palavra_16b #(
      .BYTE_ALTO_PRIMEIRO (0),
      .TIMEOUT_CICLOS     (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .dado         (dado),
      .dado_valido  (dado_valido),
      .pronto       (pronto),
      .valor        (valor),
      .load         (load),
      .palavras     (palavras),
      .erro_timeout (erro_timeout),
      .limpa_erro   (limpa_erro),
      .estado       (estado)
   );

   montador_palavra_16b #(
      .BYTE_ALTO_PRIMEIRO (1)
   ) dut_b (
      .clock        (clock),
      .reset        (reset),
      .dado         (dado),
      .dado_valido  (dado_valido),
      .pronto       (pronto_b),
      .valor        (valor_b),
      .load         (load_b),
      .palavras     (palavras_b),
      .erro_timeout (erro_timeout_b),
      .limpa_erro   (limpa_erro),
      .estado       (estado_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Downstream 16-bit load register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         registro <= 16'h0000;
      else if (load)
         registro <= valor;
   end

   task automatic ciclo();
      @(posedge clock);
      #1;
   endtask

   task automatic verifica(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic envia_byte(input logic [7:0] b);
      dado        = b;
      dado_valido = 1'b1;
      ciclo();
      dado_valido = 1'b0;
   endtask

   task automatic envia_palavra(input logic [7:0] b0, input logic [7:0] b1);
      envia_byte(b0);
      envia_byte(b1);
      ciclo();
      exp_palavras++;
   endtask

   initial begin
      n_assert     = 0;
      n_fail       = 0;
      exp_palavras = 0;
      reset        = 1'b0;
      dado         = 8'h00;
      dado_valido  = 1'b0;
      limpa_erro   = 1'b0;

      // Reset state
      repeat (2) ciclo();
      verifica("rst_valor", valor, 16'h0000);
      verifica("rst_load", load, 16'd0);
      verifica("rst_palavras", palavras, 16'd0);
      verifica("rst_erro", erro_timeout, 16'd0);
      verifica("rst_pronto", pronto, 16'd1);
      verifica("rst_estado", estado, 16'(ESPERA_PRIMEIRO));
      reset = 1'b1;
      ciclo();

      // Basic word, both byte orders
      envia_byte(8'h34);
      envia_byte(8'h12);
      verifica("w1_valor", valor, 16'h1234);
      verifica("w1_load", load, 16'd1);
      verifica("w1_pronto_entrega", pronto, 16'd0);
      verifica("w1_valor_alto", valor_b, 16'h3412);
      verifica("w1_load_alto", load_b, 16'd1);
      ciclo();
      exp_palavras++;
      verifica("w1_load_baixo", load, 16'd0);
      verifica("w1_palavras", palavras, 16'(exp_palavras));
      verifica("w1_registro", registro, 16'h1234);
      verifica("w1_pronto", pronto, 16'd1);

      // Abandoned half-word
      envia_byte(8'hAA);
      repeat (3) ciclo();
      verifica("to_erro_antes", erro_timeout, 16'd0);
      verifica("to_estado_antes", estado, 16'(ESPERA_SEGUNDO));
      ciclo();
      verifica("to_load", load, 16'd0);
      verifica("to_pronto", pronto, 16'd1);
`ifdef MONTADOR_TIMEOUT_EN
      verifica("to_erro", erro_timeout, 16'd1);
      verifica("to_estado", estado, 16'(ESPERA_PRIMEIRO));
      envia_byte(8'h01);
      envia_byte(8'h02);
      verifica("to_valor_novo", valor, 16'h0201);
`else
      verifica("to_erro", erro_timeout, 16'd0);
      verifica("to_estado", estado, 16'(ESPERA_SEGUNDO));
      envia_byte(8'h01);
      verifica("to_valor_novo", valor, 16'h01AA);
`endif
      verifica("to_load_novo", load, 16'd1);
      ciclo();
      exp_palavras++;
      verifica("to_palavras", palavras, 16'(exp_palavras));
      limpa_erro = 1'b1;
      ciclo();
      limpa_erro = 1'b0;
      verifica("to_limpa", erro_timeout, 16'd0);

      // Second byte on the expiry cycle wins
      envia_byte(8'h55);
      repeat (3) ciclo();
      envia_byte(8'h66);
      verifica("race_load", load, 16'd1);
      verifica("race_valor", valor, 16'h6655);
      verifica("race_erro", erro_timeout, 16'd0);
      ciclo();
      exp_palavras++;

      // Timeout coinciding with limpa_erro
      envia_byte(8'h77);
      repeat (3) ciclo();
      limpa_erro = 1'b1;
      ciclo();
      limpa_erro = 1'b0;
`ifdef MONTADOR_TIMEOUT_EN
      verifica("set_limpa_erro", erro_timeout, 16'd1);
      verifica("set_limpa_estado", estado, 16'(ESPERA_PRIMEIRO));
      limpa_erro = 1'b1;
      ciclo();
      limpa_erro = 1'b0;
      verifica("set_limpa_depois", erro_timeout, 16'd0);
`else
      verifica("set_limpa_erro", erro_timeout, 16'd0);
      verifica("set_limpa_estado", estado, 16'(ESPERA_SEGUNDO));
      envia_byte(8'h00);
      ciclo();
      exp_palavras++;
`endif

      // Continuous stream: byte offered during ENTREGA is dropped
      dado_valido = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         dado = 8'(i);
         ciclo();
         if (i == 2) begin
            verifica("str_load2", load, 16'd1);
            verifica("str_valor2", valor, 16'h0201);
            verifica("str_pronto2", pronto, 16'd0);
         end else if (i == 5) begin
            verifica("str_load5", load, 16'd1);
            verifica("str_valor5", valor, 16'h0504);
         end else begin
            verifica("str_load_baixo", load, 16'd0);
         end
      end
      dado_valido = 1'b0;
      exp_palavras += 2;
      verifica("str_estado_fim", estado, 16'(ESPERA_PRIMEIRO));
      verifica("str_palavras", palavras, 16'(exp_palavras));

      // Counter wrap at 256 words
      while (exp_palavras < 255)
         envia_palavra(8'(exp_palavras), ~8'(exp_palavras));
      verifica("wrap_255", palavras, 16'h00FF);
      envia_palavra(8'hC3, 8'h5A);
      verifica("wrap_0", palavras, 16'h0000);
      verifica("wrap_valor", valor, 16'h5AC3);

      // Reset between first and second byte
      envia_byte(8'h99);
      #2 reset = 1'b0;
      #1;
      verifica("mid_rst_valor", valor, 16'h0000);
      verifica("mid_rst_palavras", palavras, 16'd0);
      verifica("mid_rst_load", load, 16'd0);
      verifica("mid_rst_estado", estado, 16'(ESPERA_PRIMEIRO));
      verifica("mid_rst_pronto", pronto, 16'd1);
      #2 reset = 1'b1;
      envia_byte(8'hAB);
      envia_byte(8'hCD);
      verifica("fresh_valor", valor, 16'hCDAB);
      verifica("fresh_valor_alto", valor_b, 16'hABCD);
      verifica("fresh_load", load, 16'd1);
      ciclo();
      verifica("fresh_palavras", palavras, 16'd1);
      verifica("fresh_registro", registro, 16'hCDAB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
